// File: rtl/load_memory_unit.sv
// Load unit: accepts one load, issues a word-aligned read, and returns the extended result.
// Optional LOAD_MISALIGN_TRAP_EN: misaligned half/word loads fault instead of aligning down.
module load_memory_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    output logic        mem_rd_valid,
    input  logic        mem_rd_ready,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rdata_valid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_fault
);

    // state | meaning
    // IDLE  | ready for a new request
    // ADDR  | read request presented to memory
    // DATA  | waiting for returned word
    // RESP  | result held for writeback
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state, state_next;
    logic [2:0]  typ;
    logic [1:0]  offset;
    logic [29:0] word_addr;
    logic [31:0] data_q;
    logic        fault_q;
    logic        req_fault;

    always_comb begin
        req_fault = (req_type[1:0] == 2'b11);
`ifdef LOAD_MISALIGN_TRAP_EN
        if (req_type[1:0] == 2'b01 && req_addr[0])
            req_fault = 1'b1;
        if (req_type[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
`endif
    end

    function automatic logic [31:0] extract(input logic [2:0] t, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (t[1:0])
            2'b00:   extract = t[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   extract = t[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid)       state_next = req_fault ? RESP : ADDR;
            ADDR: if (mem_rd_ready)    state_next = DATA;
            DATA: if (mem_rdata_valid) state_next = RESP;
            RESP: if (resp_ready)      state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            typ       <= 3'b000;
            offset    <= 2'b00;
            word_addr <= 30'b0;
            data_q    <= 32'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    typ       <= req_type;
                    offset    <= req_addr[1:0];
                    word_addr <= req_addr[31:2];
                    data_q    <= 32'b0;
                    fault_q   <= req_fault;
                end
                DATA: if (mem_rdata_valid)
                    data_q <= extract(typ, offset, mem_rdata);
                default: ;
            endcase
        end
    end

    assign req_ready    = (state == IDLE);
    assign mem_rd_valid = (state == ADDR);
    assign mem_rd_addr  = {word_addr, 2'b00};
    assign resp_valid   = (state == RESP);
    assign resp_data    = data_q;
    assign resp_fault   = fault_q;

endmodule

// File: tb/tb_load_memory_unit.sv
// Bench for load_memory_unit: directed plus random loads against an arithmetic reference model.
module tb_load_memory_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic        mem_rd_valid;
    logic        mem_rd_ready;
    logic [31:0] mem_rd_addr;
    logic        mem_rdata_valid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_memory_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_addr(req_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_fault(resp_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {fault, data} for a load, from the ISA meaning of each load type.
    function automatic logic [32:0] model(input logic [2:0] t, input logic [31:0] a,
                                          input logic [31:0] d);
        int unsigned off;
        logic [31:0] v;
        off = a % 4;
        if (t[1:0] == 2'b11) return {1'b1, 32'h0};
`ifdef LOAD_MISALIGN_TRAP_EN
        if (t[1:0] == 2'b01 && (off % 2) == 1) return {1'b1, 32'h0};
        if (t[1:0] == 2'b10 && off != 0) return {1'b1, 32'h0};
`endif
        if (t[1:0] == 2'b00) begin
            v = (d >> (8 * off)) & 32'hFF;
            if (!t[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (t[1:0] == 2'b01) begin
            v = (d >> (16 * (off / 2))) & 32'hFFFF;
            if (!t[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return {1'b0, v};
    endfunction

    task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                           input int rd_stall, input int dly, input int rsp_stall);
        logic [32:0] exp;
        exp = model(t, a, d);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        req_type  = 3'($urandom);
        req_addr  = $urandom;
        if (exp[32]) begin
            check("fault_mem_rd_valid", mem_rd_valid, 1'b0);
        end else begin
            check("rd_valid", mem_rd_valid, 1'b1);
            check("rd_addr", mem_rd_addr, a & 32'hFFFF_FFFC);
            for (int i = 0; i < rd_stall; i++) begin
                mem_rdata_valid = 1'b1;
                mem_rdata = $urandom;
                req_valid = 1'b1;
                @(negedge clk);
                mem_rdata_valid = 1'b0;
                req_valid = 1'b0;
                check("stall_rd_valid", mem_rd_valid, 1'b1);
                check("stall_rd_addr", mem_rd_addr, a & 32'hFFFF_FFFC);
                check("stall_req_ready", req_ready, 1'b0);
            end
            mem_rd_ready = 1'b1;
            @(negedge clk);
            mem_rd_ready = 1'b0;
            check("data_rd_valid", mem_rd_valid, 1'b0);
            check("data_resp_valid", resp_valid, 1'b0);
            repeat (dly) @(negedge clk);
            mem_rdata_valid = 1'b1;
            mem_rdata = d;
            @(negedge clk);
            mem_rdata_valid = 1'b0;
            mem_rdata = $urandom;
        end
        check("resp_valid", resp_valid, 1'b1);
        check("resp_fault", resp_fault, exp[32]);
        check("resp_data", resp_data, exp[31:0]);
        for (int i = 0; i < rsp_stall; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check("hold_resp_valid", resp_valid, 1'b1);
            check("hold_resp_data", resp_data, exp[31:0]);
            check("hold_resp_fault", resp_fault, exp[32]);
            check("hold_req_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b0;
        check("post_resp_valid", resp_valid, 1'b0);
        check("post_req_ready", req_ready, 1'b1);
        check("post_rd_valid", mem_rd_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_type = 3'b0;
        req_addr = 32'h0;
        mem_rd_ready = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata = 32'h0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rd_valid", mem_rd_valid, 1'b0);
        check("rst_rd_addr", mem_rd_addr, 32'h0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_fault", resp_fault, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        do_load(3'b000, 32'h103, 32'h8000_0000, 0, 0, 0);
        do_load(3'b100, 32'h103, 32'h8000_0000, 0, 0, 0);
        do_load(3'b001, 32'h202, 32'h8001_ABCD, 0, 0, 0);
        do_load(3'b101, 32'h200, 32'h8001_ABCD, 0, 0, 0);
        do_load(3'b010, 32'h40, 32'hDEAD_BEEF, 3, 0, 5);
        do_load(3'b001, 32'h301, 32'h1234_F00D, 0, 1, 0);
        do_load(3'b110, 32'h7A, 32'h89AB_CDEF, 1, 0, 0);
        do_load(3'b011, 32'h80, 32'h1111_1111, 0, 0, 2);
        do_load(3'b111, 32'h84, 32'h2222_2222, 0, 0, 0);

        // Reset while waiting for data; a late rdata pulse must not produce a response.
        req_valid = 1'b1;
        req_type  = 3'b010;
        req_addr  = 32'h500;
        @(negedge clk);
        req_valid = 1'b0;
        mem_rd_ready = 1'b1;
        @(negedge clk);
        mem_rd_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_req_ready", req_ready, 1'b1);
        check("mid_rst_rd_valid", mem_rd_valid, 1'b0);
        check("mid_rst_rd_addr", mem_rd_addr, 32'h0);
        mem_rdata_valid = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        check("late_rdata_resp_valid", resp_valid, 1'b0);
        check("late_rdata_req_ready", req_ready, 1'b1);
        @(negedge clk);
        check("late_rdata_resp_valid2", resp_valid, 1'b0);
        do_load(3'b010, 32'h600, 32'hCAFE_F00D, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            do_load(3'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
